// File: rtl/board_write_arbiter_if.sv
// Write-port bundle between the board requesters and the arbiter.
interface board_write_arbiter_if #(
  parameter int AW = 11,
  parameter int DW = 2
);
  logic          safe;
  logic [2:0]    req;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [AW-1:0] addr2;
  logic [DW-1:0] data0;
  logic [DW-1:0] data1;
  logic [DW-1:0] data2;
  logic [2:0]    gnt;
  logic          collide;
  logic          err;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [2:0]    stall;
  logic          busy;

  modport master (
    output safe, req, addr0, addr1, addr2, data0, data1, data2,
    input  gnt, collide, err, we, waddr, wdata, stall, busy
  );

  modport slave (
    input  safe, req, addr0, addr1, addr2, data0, data1, data2,
    output gnt, collide, err, we, waddr, wdata, stall, busy
  );
endinterface

// File: rtl/board_write_arbiter.sv
// Board store write-port arbiter: snake1 / snake2 round-robin, apple last,
// writes only inside the display blanking window.
//
//   state  | meaning
//   CLOSED | display reading the board, no grants
//   OPEN   | window open, one grant decision per cycle
//   DRAIN  | one cycle after the window closes; last grant is on the bus
//
// A grant is decided in a cycle whose state is OPEN and appears on the
// registered outputs after the following edge. From CLOSED the first edge
// with safe=1 only opens the window, so the first grant follows one edge later.
module board_write_arbiter #(
  parameter int CELLS    = 1600,
  parameter int AW       = 11,
  parameter int DW       = 2,
  parameter int MAX_WAIT = 2
) (
  input logic             clk,
  input logic             rst,
  board_write_arbiter_if.slave bus
);

  typedef enum logic [1:0] {CLOSED = 2'd0, OPEN = 2'd1, DRAIN = 2'd2} state_t;

  localparam logic [AW:0] CELLS_L = CELLS[AW:0];

  state_t        state, state_nxt;
  logic [2:0]    gnt_q;
  logic          collide_q, err_q, we_q, busy_q;
  logic [AW-1:0] waddr_q;
  logic [DW-1:0] wdata_q;
  logic [2:0]    stall_q;
  logic [1:0]    cnt_q [3];
  logic          ptr_q;     // 0: snake1 wins a tie, 1: snake2 wins a tie
  logic          coll_q;    // next snake grant is the loser of a head-on write
  logic          safe_q;

  logic [2:0]    pend;
  logic [2:0]    pick;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          sel_oor, coll_set, pick_coll, pick_we, fall;

  // A requester granted last cycle still holds req this cycle; mask it.
  assign pend = bus.req & ~gnt_q;
  assign fall = safe_q & ~bus.safe;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= CLOSED;
    else     state <= state_nxt;
  end

  // Next-state logic for the write window.
  always_comb begin
    state_nxt = state;
    case (state)
      CLOSED:  if (bus.safe) state_nxt = OPEN;
      OPEN:    if (!bus.safe) state_nxt = DRAIN;
      DRAIN:   state_nxt = bus.safe ? OPEN : CLOSED;
      default: state_nxt = CLOSED;
    endcase
  end

  // Grant decision and selected write for this cycle.
  always_comb begin
    pick     = 3'b000;
    sel_addr = bus.addr0;
    sel_data = bus.data0;
    if (state == OPEN) begin
      if (pend[0] && pend[1]) pick = ptr_q ? 3'b010 : 3'b001;
      else if (pend[0])       pick = 3'b001;
      else if (pend[1])       pick = 3'b010;
      else if (pend[2])       pick = 3'b100;
    end
    if (pick[1]) begin
      sel_addr = bus.addr1;
      sel_data = bus.data1;
    end else if (pick[2]) begin
      sel_addr = bus.addr2;
      sel_data = bus.data2;
    end
    sel_oor   = ({1'b0, sel_addr} >= CELLS_L);
    coll_set  = (state == OPEN) && pend[0] && pend[1] && (bus.addr0 == bus.addr1);
    pick_coll = coll_q && (pick[0] || pick[1]);
    pick_we   = (|pick) && !sel_oor && !pick_coll;
  end

  // Registered grant, write port and arbitration bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q     <= '0;
      collide_q <= 1'b0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      ptr_q     <= 1'b0;
      coll_q    <= 1'b0;
      safe_q    <= 1'b0;
    end else begin
      gnt_q     <= pick;
      collide_q <= pick_coll;
      err_q     <= (|pick) && sel_oor;
      we_q      <= pick_we;
      busy_q    <= |bus.req;
      safe_q    <= bus.safe;
      if (pick_we) begin
        waddr_q <= sel_addr;
        wdata_q <= sel_data;
      end
      // Winner grant arms the flag; the loser's grant sees the winner masked
      // and therefore clears it.
      if (pick[0] || pick[1]) begin
        ptr_q  <= pick[0];
        coll_q <= coll_set;
      end
    end
  end

  // Per-requester wait counters over closing windows, sticky stall flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (pick[k])
          cnt_q[k] <= '0;
        else if (fall && pend[k] && cnt_q[k] != 2'd3)
          cnt_q[k] <= cnt_q[k] + 2'd1;
        if (int'(cnt_q[k]) > MAX_WAIT) stall_q[k] <= 1'b1;
      end
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.collide = collide_q;
  assign bus.err     = err_q;
  assign bus.we      = we_q;
  assign bus.waddr   = waddr_q;
  assign bus.wdata   = wdata_q;
  assign bus.stall   = stall_q;
  assign bus.busy    = busy_q;

endmodule
